// File: rtl/axis_md_frame_splitter_if.sv
// axis_md_frame_splitter_if: AXI-Stream beat bundle (tdata/tvalid/tlast/tready)
// shared by the splitter input and both of its outputs.
interface axis_md_frame_splitter_if #(parameter int DW = 128);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_md_frame_splitter.sv
// axis_md_frame_splitter: routes the first MD_WORDS beats of each frame to out1 and the rest to out2,
// or duplicates every beat to both outputs in broadcast mode. Optional macro: TLAST_CHECK_EN.
module axis_md_frame_splitter #(
    parameter int DW          = 128,
    parameter int MD_WORDS    = 4,
    parameter int FRAME_WORDS = 1024,
    localparam int CW         = $clog2(MD_WORDS + FRAME_WORDS + 1)
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             md_enable,
    axis_md_frame_splitter_if.slave          axis_in,
    axis_md_frame_splitter_if.master         axis_out1,
    axis_md_frame_splitter_if.master         axis_out2,
    output logic [31:0]                      frame_cnt,
    output logic                             frame_err
);
    typedef enum logic {HDR, PAY} state_t;
    localparam logic [CW-1:0] LAST_CNT = CW'(MD_WORDS + FRAME_WORDS - 1);
    localparam logic [CW-1:0] HDR_LAST = CW'(MD_WORDS - 1);
    state_t        r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic          r_mode, r_v1, r_v2, r_l1, r_l2, r_err;
    logic [DW-1:0] r_d1, r_d2;
    logic [31:0]   r_fcnt;
    logic          w_free1, w_free2, w_acc, w_mode, w_last, w_hdr_last, w_end, w_mis, w_ld1, w_ld2;
    assign w_free1        = ~r_v1 | axis_out1.tready;
    assign w_free2        = ~r_v2 | axis_out2.tready;
    assign axis_in.tready = w_free1 & w_free2 & resetn;
    assign w_acc          = axis_in.tvalid & axis_in.tready;
    // The frame's first beat is routed with the freshly sampled mode.
    assign w_mode         = (r_cnt == '0) ? md_enable : r_mode;
    assign w_last         = r_cnt == LAST_CNT;
    assign w_hdr_last     = r_cnt == HDR_LAST;
`ifdef TLAST_CHECK_EN
    assign w_end          = w_last | axis_in.tlast;
    assign w_mis          = axis_in.tlast ^ w_last;
`else
    assign w_end          = w_last;
    assign w_mis          = axis_in.tlast & 1'b0;
`endif
    assign w_ld1          = w_acc & (~w_mode | (r_state == HDR));
    assign w_ld2          = w_acc & (~w_mode | (r_state == PAY));
    always_comb begin
        w_cnt_n   = r_cnt;
        w_state_n = r_state;
        if (w_acc) begin
            w_cnt_n   = w_end ? '0 : r_cnt + 1'b1;
            w_state_n = w_end ? HDR : (w_hdr_last ? PAY : r_state);
        end
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= HDR;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_l1    <= 1'b0;
            r_l2    <= 1'b0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_fcnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            if (w_acc && r_cnt == '0)
                r_mode <= md_enable;
            r_v1 <= w_ld1 | (r_v1 & ~axis_out1.tready);
            r_v2 <= w_ld2 | (r_v2 & ~axis_out2.tready);
            if (w_ld1) begin
                r_d1 <= axis_in.tdata;
                r_l1 <= w_mode ? (w_hdr_last | w_end) : w_end;
            end
            if (w_ld2) begin
                r_d2 <= axis_in.tdata;
                r_l2 <= w_end;
            end
            r_fcnt <= r_fcnt + 32'(w_acc & w_end);
            r_err  <= r_err | (w_acc & w_mis);
        end
    end
    assign axis_out1.tdata  = r_d1;
    assign axis_out1.tvalid = r_v1;
    assign axis_out1.tlast  = r_l1;
    assign axis_out2.tdata  = r_d2;
    assign axis_out2.tvalid = r_v2;
    assign axis_out2.tlast  = r_l2;
    assign frame_cnt        = r_fcnt;
    assign frame_err        = r_err;
endmodule
